thirty_two_bit_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_bit_slice.sv | 34 +++
 rtl/thirty_two_bit_alu.sv | 49 ++++
 tb/tb_thirty_two_bit_alu.sv | 126 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and the opcode type used by the ALU slice and top.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_AND = 3'b000;
  localparam alu_op_t ALU_OR  = 3'b001;
  localparam alu_op_t ALU_ADD = 3'b010;
  localparam alu_op_t ALU_SUB = 3'b110;
  localparam alu_op_t ALU_XOR = 3'b111;

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ALU: logic ops plus a full adder with optional B inversion.
// Purely combinational; unused opcodes yield a 0 bit.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic    a_i,
  input  logic    b_i,
  input  logic    carry_in,
  input  logic    b_invert,
  input  alu_op_t op,
  output logic    result,
  output logic    carry_out
);

  logic b_eff;
  logic sum;

  assign b_eff     = b_i ^ b_invert;
  assign sum       = a_i ^ b_eff ^ carry_in;
  assign carry_out = (a_i & b_eff) | (a_i & carry_in) | (b_eff & carry_in);

  always_comb begin
    result = 1'b0;
    case (op)
      ALU_AND: result = a_i & b_i;
      ALU_OR:  result = a_i | b_i;
      ALU_ADD: result = sum;
      ALU_SUB: result = sum;
      ALU_XOR: result = a_i ^ b_i;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/thirty_two_bit_alu.sv
// 32-bit MIPS ALU built from ripple-carry bit slices; result and zero are
// registered, one cycle latency, a new operation every cycle with no backpressure.
module thirty_two_bit_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic             zero,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] slice_res;
  logic             sub_sel;
  logic             unused_carry;

  // SUB reuses the adder as a + ~b + 1.
  assign sub_sel      = (op == ALU_SUB);
  assign carry[0]     = sub_sel;
  assign unused_carry = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu_bit_slice u_slice (
      .a_i       (a[i]),
      .b_i       (b[i]),
      .carry_in  (carry[i]),
      .b_invert  (sub_sel),
      .op        (op),
      .result    (slice_res[i]),
      .carry_out (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
    end else begin
      result <= slice_res;
    end
  end

  assign zero = ~|result;

endmodule

// File: tb/tb_thirty_two_bit_alu.sv
// Directed self-checking bench for thirty_two_bit_alu.
module tb_thirty_two_bit_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        zero;
  logic [31:0] result;

  int tests;
  int fails;

  thirty_two_bit_alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .op     (op),
    .zero   (zero),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] exp_res, input logic exp_zero);
    tests++;
    assert (result === exp_res) else begin
      fails++;
      $error("FAIL %s result observed=%h expected=%h", tag, result, exp_res);
    end
    tests++;
    assert (zero === exp_zero) else begin
      fails++;
      $error("FAIL %s zero observed=%b expected=%b", tag, zero, exp_zero);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit later.
  task automatic step(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] opv);
    a  = av;
    b  = bv;
    op = opv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a     = 32'h1234_5678;
    b     = 32'h0000_0001;
    op    = 3'b010;
    #2;

    // Reset held for two cycles with live inputs
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; op = 3'b001;
    @(posedge clk); #1;
    chk("reset", 32'h0000_0000, 1'b1);

    rst_n = 1'b1;
    step(32'hFFFF_0000, 32'h0000_FFFF, 3'b001);
    chk("or_after_reset", 32'hFFFF_FFFF, 1'b0);

    step(32'hFFFF_0000, 32'h0000_FFFF, 3'b000);
    chk("and", 32'h0000_0000, 1'b1);

    step(32'hFFFF_0000, 32'h0000_FFFF, 3'b010);
    chk("add", 32'hFFFF_FFFF, 1'b0);

    // New inputs must not show before the next edge
    a = 32'h0000_FFFF; b = 32'h0000_FFFF; op = 3'b110;
    #2;
    chk("hold_before_edge", 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    chk("sub_equal", 32'h0000_0000, 1'b1);

    step(32'h0000_FFFF, 32'h0F0F_F0F0, 3'b111);
    chk("xor", 32'h0F0F_0F0F, 1'b0);

    step(32'hFFFF_FFFF, 32'h0000_0001, 3'b010);
    chk("add_wrap", 32'h0000_0000, 1'b1);

    step(32'h0000_0000, 32'h0000_0001, 3'b110);
    chk("sub_wrap", 32'hFFFF_FFFF, 1'b0);

    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011);
    chk("unused_011", 32'h0000_0000, 1'b1);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100);
    chk("unused_100", 32'h0000_0000, 1'b1);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101);
    chk("unused_101", 32'h0000_0000, 1'b1);

    // Back-to-back stream with op changing every cycle
    step(32'h1234_5678, 32'h1111_1111, 3'b010);
    chk("b2b_add", 32'h2345_6789, 1'b0);
    step(32'h1234_5678, 32'h0000_0679, 3'b110);
    chk("b2b_sub", 32'h1234_4FFF, 1'b0);
    step(32'hA5A5_A5A5, 32'h0F0F_0F0F, 3'b000);
    chk("b2b_and", 32'h0505_0505, 1'b0);
    step(32'hA5A5_A5A5, 32'h0F0F_0F0F, 3'b001);
    chk("b2b_or", 32'hAFAF_AFAF, 1'b0);
    step(32'hA5A5_A5A5, 32'h0F0F_0F0F, 3'b111);
    chk("b2b_xor", 32'hAAAA_AAAA, 1'b0);
    step(32'h8000_0000, 32'h8000_0000, 3'b010);
    chk("b2b_add_carry_out", 32'h0000_0000, 1'b1);
    step(32'h0000_0005, 32'h0000_0007, 3'b110);
    chk("b2b_sub_neg", 32'hFFFF_FFFE, 1'b0);

    // Mid-stream reset overrides the operation on the same edge
    rst_n = 1'b0;
    step(32'hFFFF_0000, 32'h0000_FFFF, 3'b001);
    chk("midstream_reset", 32'h0000_0000, 1'b1);
    rst_n = 1'b1;
    step(32'h0000_0001, 32'h0000_0002, 3'b010);
    chk("after_midstream_reset", 32'h0000_0003, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
